// File: rtl/joy_db15_tx.sv
// joy_db15_tx: DB15 joystick serial transmitter, two 12-button pads shifted out LSB first.
// JOY_CLK/JOY_LOAD are asynchronous, so both are synchronized and edge-detected on clk.
module joy_db15_tx #(
  parameter int FRAME_BITS  = 24,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] joystick1,
  input  logic [11:0] joystick2,
  input  logic        JOY_CLK,
  input  logic        JOY_LOAD,
  output logic        JOY_DATA,
  output logic        frame_done,
  output logic [4:0]  bit_cnt,
  output logic        timeout_err
);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_clk_sync, r_load_sync;
  logic [SYNC_STAGES:0]   w_clk_chain, w_load_chain;
  logic                   r_clk_prev, r_load_prev;
  logic [FRAME_BITS-1:0]  r_sr;
  logic [WDW-1:0]         r_wd;
  logic [4:0]             r_bit_cnt;
  logic                   r_frame_done, r_timeout_err;
  logic w_clk_s, w_load_s, w_clk_rise, w_clk_edge, w_load_edge, w_load_lo;
  logic w_timeout, w_shift, w_last;
  assign w_clk_chain  = {r_clk_sync, JOY_CLK};
  assign w_load_chain = {r_load_sync, JOY_LOAD};
  assign w_clk_s      = r_clk_sync[SYNC_STAGES-1];
  assign w_load_s     = r_load_sync[SYNC_STAGES-1];
  assign w_clk_rise   = w_clk_s & ~r_clk_prev;
  assign w_clk_edge   = w_clk_s ^ r_clk_prev;
  assign w_load_edge  = w_load_s ^ r_load_prev;
  assign w_load_lo    = ~w_load_s;
  assign w_timeout    = (r_state == SHIFT) && (r_wd == WD_MAX);
  assign w_shift      = w_clk_rise && (r_state == SHIFT || r_state == DONE);
  assign w_last       = (r_state == SHIFT) && w_clk_rise && (r_bit_cnt == 5'(FRAME_BITS - 1));
  // Load dominates everything; a timeout beats a coincident final shift edge.
  always_comb begin
    w_next = w_load_lo ? LOAD :
             (r_state == LOAD) ? SHIFT :
             w_timeout ? IDLE :
             w_last ? DONE : r_state;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_clk_sync    <= '1;
      r_load_sync   <= '1;
      r_clk_prev    <= 1'b1;
      r_load_prev   <= 1'b1;
      r_sr          <= '1;
      r_wd          <= '0;
      r_bit_cnt     <= '0;
      r_frame_done  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_clk_sync   <= w_clk_chain[SYNC_STAGES-1:0];
      r_load_sync  <= w_load_chain[SYNC_STAGES-1:0];
      r_clk_prev   <= w_clk_s;
      r_load_prev  <= w_load_s;
      r_state      <= w_next;
      r_wd         <= (w_clk_edge | w_load_edge) ? '0 : (r_wd == WD_MAX) ? r_wd : r_wd + 1'b1;
      r_frame_done <= w_last && !w_load_lo && !w_timeout;
      if (w_load_lo) begin
        r_sr          <= FRAME_BITS'(~{joystick2, joystick1});
        r_bit_cnt     <= '0;
        r_timeout_err <= 1'b0;
      end else if (w_timeout) begin
        r_sr          <= '1;
        r_timeout_err <= 1'b1;
      end else if (w_shift) begin
        r_sr      <= {1'b1, r_sr[FRAME_BITS-1:1]};
        r_bit_cnt <= (r_bit_cnt == 5'(FRAME_BITS)) ? r_bit_cnt : r_bit_cnt + 1'b1;
      end
    end
  end
  assign JOY_DATA    = r_sr[0];
  assign frame_done  = r_frame_done;
  assign bit_cnt     = r_bit_cnt;
  assign timeout_err = r_timeout_err;
endmodule

// File: doc/joy_db15_tx.md
JOY_DB15_TX -- requirements
Module: joy_db15_tx

Interface
REQ-001 The module SHALL have parameter FRAME_BITS, default 24, giving serial frame length in bits (two players x 12).
REQ-002 The module SHALL have parameter SYNC_STAGES, default 2, giving synchronizer depth for the JOY_CLK/JOY_LOAD inputs.
REQ-003 The module SHALL have parameter TIMEOUT, default 65535, giving idle clk cycles before a partial frame is abandoned.
REQ-004 The module SHALL have port clk, input, 1, system clock at 40-50 MHz.
REQ-005 The module SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 The module SHALL have port joystick1, input, 12, player 1 buttons, active-high, bit map FEDCBAUDLR plus bits 11:10 = L,S.
REQ-007 The module SHALL have port joystick2, input, 12, player 2 buttons in the same bit map.
REQ-008 The module SHALL have port JOY_CLK, input, 1, shift clock from the reader, asynchronous to clk.
REQ-009 The module SHALL have port JOY_LOAD, input, 1, active-low parallel load from the reader, asynchronous to clk.
REQ-010 The module SHALL have port JOY_DATA, output, 1, serial data to the reader, active-low (0 = pressed).
REQ-011 The module SHALL have port frame_done, output, 1, one-cycle pulse when bit FRAME_BITS-1 has been shifted out.
REQ-012 The module SHALL have port bit_cnt, output, 5, bits shifted since last load.
REQ-013 The module SHALL have port timeout_err, output, 1, sticky flag set on a timed-out partial frame, cleared by next load.

Function
REQ-014 JOY_CLK and JOY_LOAD SHALL each pass through SYNC_STAGES flip-flops on clk before any use; edges SHALL be detected on synchronized values only.
REQ-015 The shift register SHALL be FRAME_BITS wide; serial order SHALL be joystick1[0..11] then joystick2[0..11], LSB first.
REQ-016 JOY_DATA SHALL equal shift register bit 0 in every cycle.
REQ-017 States SHALL be IDLE, LOAD, SHIFT, DONE.
REQ-018 While synchronized JOY_LOAD is low (any state): state = LOAD; each cycle, shift register <= ~{joystick2, joystick1}; bit_cnt <= 0; timeout_err <= 0; JOY_CLK edges ignored.
REQ-019 LOAD -> SHIFT on JOY_LOAD rising edge; register holds the last loaded value.
REQ-020 In SHIFT, each synchronized JOY_CLK rising edge SHALL shift right by one, fill MSB with 1, increment bit_cnt; falling edges SHALL have no effect.
REQ-021 When bit_cnt reaches FRAME_BITS: frame_done pulses high for exactly one cycle, state -> DONE.
REQ-022 In DONE, further JOY_CLK edges SHALL continue shifting in 1s (JOY_DATA = 1); bit_cnt SHALL saturate at FRAME_BITS.
REQ-023 JOY_DATA change SHALL follow the JOY_CLK pin rising edge by SYNC_STAGES+1 clk cycles (3 at default).
REQ-024 A watchdog counter SHALL reset on every synchronized JOY_CLK or JOY_LOAD edge; if in SHIFT it reaches TIMEOUT: timeout_err <= 1, shift register <= all 1s, state -> IDLE.
REQ-025 In IDLE, JOY_CLK edges SHALL be ignored and JOY_DATA SHALL be 1.
REQ-026 Joystick input changes outside LOAD SHALL not affect the frame in progress.

Reset
REQ-027 On reset_n low, asynchronously: state = IDLE, shift register = all 1s, JOY_DATA = 1, bit_cnt = 0, frame_done = 0, timeout_err = 0, synchronizers = 1, watchdog = 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; after release, first action SHALL require a new JOY_LOAD low.

Verification
REQ-029 joystick1=12'h001, joystick2=0, load pulse, 24 JOY_CLK pulses -> JOY_DATA sequence 0 then 23 ones; frame_done one pulse after 24th edge.
REQ-030 joystick1=12'hA5A, joystick2=12'h3C3 -> captured 24-bit word (LSB first) equals ~24'h3C3A5A.
REQ-031 Load, 10 clocks, new load, 24 clocks -> bit_cnt returns to 0 at second load; full correct frame; exactly one frame_done.
REQ-032 Load, 5 clocks, no activity TIMEOUT cycles (TIMEOUT=100 in bench) -> timeout_err=1, JOY_DATA=1, state IDLE; next load clears timeout_err.
REQ-033 30 clocks after load -> bits 25-30 read 1, bit_cnt stays 24, single frame_done.
REQ-034 reset_n low at bit 12 -> JOY_DATA=1 immediately, bit_cnt=0; clocks before next load produce no shift.
